// File: rtl/cic_filter_core.sv
// Decimating CIC filter: N registered integrators at the input rate, N combs
// (differential delay 1) at the output rate, output scaled to unity DC gain.
module cic_filter_core #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned DECIMATION_FACTOR = 4,
  parameter int unsigned NUM_STAGES        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid
);

  localparam int unsigned LOG2R = $clog2(DECIMATION_FACTOR);
  localparam int unsigned SHIFT = NUM_STAGES * LOG2R;
  localparam int unsigned W     = DATA_WIDTH + SHIFT;
  localparam logic [LOG2R-1:0] CNT_LAST = LOG2R'(DECIMATION_FACTOR - 1);

  if ((DECIMATION_FACTOR < 2) ||
      ((DECIMATION_FACTOR & (DECIMATION_FACTOR - 1)) != 0)) begin : g_bad_rate
    $error("cic_filter_core: DECIMATION_FACTOR must be a power of two >= 2");
  end
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("cic_filter_core: NUM_STAGES must be >= 1");
  end

  logic [LOG2R-1:0]      r_cnt;
  logic signed [W-1:0]   r_integ [NUM_STAGES];
  logic signed [W-1:0]   r_delay [NUM_STAGES];
  logic signed [W-1:0]   w_comb  [NUM_STAGES+1];
  logic signed [W-1:0]   w_in_ext;
  logic                  w_tick;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_out_valid;

  assign w_in_ext  = W'($signed(data_in));
  assign w_tick    = (r_cnt == CNT_LAST);
  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;

  // Comb chain evaluated on the last integrator value; only consumed on a tick.
  always_comb begin
    w_comb[0] = r_integ[NUM_STAGES-1];
    for (int k = 1; k <= NUM_STAGES; k++) begin
      w_comb[k] = w_comb[k-1] - r_delay[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_integ[k] <= '0;
        r_delay[k] <= '0;
      end
    end else begin
      r_cnt       <= r_cnt + LOG2R'(1);
      r_out_valid <= w_tick;
      // Integrators wrap modulo 2^W; the combs undo the wrap exactly.
      r_integ[0]  <= r_integ[0] + w_in_ext;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
      if (w_tick) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          r_delay[k] <= w_comb[k];
        end
        r_data_out <= DATA_WIDTH'(w_comb[NUM_STAGES] >>> SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_cic_filter_core.sv
// Directed and random checks of cic_filter_core (R=4, N=3, 16-bit) against an
// ideal boxcar^N convolution model with floor division by R^N.
module tb_cic_filter_core;

  localparam int R = 4;
  localparam int N = 3;
  localparam int HLEN = N * (R - 1) + 1;
  localparam int GAIN = 64;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        out_valid;

  cic_filter_core #(
    .DATA_WIDTH(16),
    .DECIMATION_FACTOR(R),
    .NUM_STAGES(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      x;
    logic [4:0][15:0] exp;
  } vec_t;

  int   n_checks;
  int   n_fail;
  int   h [HLEN];
  int   hist [$];
  int   exp_out;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int x, input int e0, input int e1,
                              input int e2, input int e3, input int e4);
    vec_t v;
    v.x      = 16'(x);
    v.exp[0] = 16'(e0);
    v.exp[1] = 16'(e1);
    v.exp[2] = 16'(e2);
    v.exp[3] = 16'(e3);
    v.exp[4] = 16'(e4);
    return v;
  endfunction

  // Ideal output for a tick at edge e (edges numbered from 1 after release).
  function automatic int model(input int e);
    longint acc;
    longint q;
    int     m;
    acc = 0;
    for (int k = 0; k < HLEN; k++) begin
      m = e - N - k;
      if (m >= 1) acc += longint'(h[k]) * longint'(hist[m-1]);
    end
    q = acc / GAIN;
    if ((acc % GAIN != 0) && (acc < 0)) q -= 1;
    return int'(q);
  endfunction

  task automatic do_reset(input int cycles, input logic [15:0] din);
    reset   = 1'b1;
    data_in = din;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_dout", int'($signed(data_out)), 0);
    end
    reset = 1'b0;
    hist.delete();
    exp_out = 0;
  endtask

  task automatic step(input logic [15:0] x, output logic v, output int dout);
    int e;
    data_in = x;
    hist.push_back(int'($signed(x)));
    @(posedge clk); #1;
    e = hist.size();
    v = ((e % R) == 0);
    chk("out_valid", int'(out_valid), int'(v));
    if (v) exp_out = model(e);
    dout = int'($signed(data_out));
    chk("data_out", dout, exp_out);
  endtask

  task automatic run_const(input vec_t vec, input string name);
    logic v;
    int   d;
    int   vi;
    vi = 0;
    for (int s = 0; s < 24; s++) begin
      step(vec.x, v, d);
      if (v) begin
        if (vi < 5) chk(name, d, int'($signed(vec.exp[vi])));
        else chk(name, d, int'($signed(vec.x)));
        vi++;
      end
    end
  endtask

  initial begin
    int   tmp [HLEN];
    int   cur_len;
    logic v;
    int   d;
    int   vi;
    int   sum;
    int   bad;
    int   late_nz;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    data_in  = '0;

    // Impulse response of N cascaded length-R boxcars.
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    cur_len = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HLEN; i++) tmp[i] = 0;
      for (int i = 0; i < cur_len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      cur_len += R - 1;
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end

    vecs[0] = mk(100,     1,      50,     98,     100,    100);
    vecs[1] = mk(-32768, -512,   -16384, -32256, -32768, -32768);
    vecs[2] = mk(32767,   511,    16383,  32255,  32767,  32767);
    vecs[3] = mk(-1,     -1,     -1,     -1,     -1,     -1);
    vecs[4] = mk(1,       0,      0,      0,      1,      1);
    vecs[5] = mk(-100,   -2,     -50,    -99,    -100,   -100);

    for (int i = 0; i < 6; i++) begin
      do_reset(2, 16'h1234);
      run_const(vecs[i], "const_vec");
    end

    // Single impulse followed by zeros.
    do_reset(2, 16'h1234);
    sum = 0; bad = 0; late_nz = 0; vi = 0;
    step(16'd4096, v, d);
    for (int s = 0; s < 40; s++) begin
      step(16'd0, v, d);
      if (v) begin
        sum += d;
        if ((d % 64) != 0) bad++;
        if (vi >= 4 && d != 0) late_nz++;
        vi++;
      end
    end
    chk("impulse_sum", sum, 1024);
    chk("impulse_mult64", bad, 0);
    chk("impulse_tail_zero", late_nz, 0);

    // Random stream against the ideal model.
    do_reset(1, 16'hFFFF);
    for (int s = 0; s < 1000; s++) step(16'($urandom()), v, d);

    // Mid-run reset must discard all history.
    do_reset(1, 16'h1234);
    for (int s = 0; s < 500; s++) step(16'($urandom()), v, d);
    do_reset(1, 16'(int'($urandom())));
    run_const(vecs[0], "post_reset_const");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_filter_core.md
CIC_FILTER_CORE -- requirements
Module: cic_filter

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, giving the input and output sample width in bits.
REQ-002 SHALL provide parameter DECIMATION_FACTOR, default 4, giving the rate change R; it must be a power of two and at least 2.
REQ-003 SHALL provide parameter NUM_STAGES, default 3, giving the integrator count and the comb count N (N >= 1); differential delay is fixed at 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port data_in, input, DATA_WIDTH bits: signed two's-complement sample, one new sample every clock.
REQ-008 Port data_out, output, DATA_WIDTH bits: signed two's-complement decimated sample, registered, held between updates.
REQ-009 Port out_valid, output, 1 bit: one-cycle pulse marking the clock in which data_out takes a new value.

Function
REQ-010 Internal width SHALL be W = DATA_WIDTH + NUM_STAGES*log2(DECIMATION_FACTOR); all integrator, comb and delay registers are W bits wide and signed.
REQ-011 Integrators SHALL be registered and SHALL update every clock when reset is low.
- I1 <= I1 + sign-extended data_in.
- Ik <= Ik + I(k-1) for k = 2..N.
- Wrap-around is modulo 2^W, with no saturation.
REQ-012 The decimation counter SHALL count 0..R-1 every clock, wrap to 0, and assert tick when it equals R-1.
REQ-013 On a tick, the comb chain SHALL operate on IN.
- c0 = IN.
- ck = c(k-1) - dk.
- dk <= c(k-1) for k = 1..N, all subtractions modulo 2^W.
- Delay registers dk SHALL hold their values when there is no tick.
REQ-014 On a tick, data_out SHALL load bits [W-1 : W-DATA_WIDTH] of cN, i.e. an arithmetic right shift by N*log2(R) with truncation toward minus infinity, so DC gain is exactly 1.
REQ-015 out_valid SHALL be 1 in the clock after a tick edge and 0 otherwise; data_out SHALL change only when out_valid rises.
REQ-016 Output rate SHALL be one sample per R clocks; the first out_valid SHALL occur R clocks after reset deasserts.
REQ-017 For a constant input x held from reset release, data_out SHALL equal x exactly from the (N+1)-th valid output onward.
REQ-018 For any input sequence, data_out SHALL match the ideal integer model, floor((sum of (boxcar length R)^N impulse response * input) / R^N), sampled at each tick.

Reset
REQ-019 While reset is high at a clock edge, the following SHALL be cleared to 0: all integrators, comb delays, the decimation counter, data_out and out_valid.
REQ-020 Reset asserted mid-operation SHALL discard all history; behaviour after release SHALL be identical to that after power-on reset.
REQ-021 data_in SHALL be ignored while reset is high.

Verification
REQ-022 Reset held 2 clocks with data_in = 0x1234 -> data_out = 0 and out_valid = 0 throughout; after release, first out_valid occurs 4 clocks later.
REQ-023 Constant data_in = 100 from release -> outputs rise monotonically, then data_out = 100 on every valid from the 4th onward.
REQ-024 Constant data_in = -32768 (0x8000) -> data_out settles to -32768 exactly, with no overflow artefact.
REQ-025 Single impulse of 4096 followed by zeros -> nonzero outputs are multiples of 64, sum of all valid outputs = 1024, and outputs are 0 after at most 4 valid samples.
REQ-026 1000 random 16-bit samples -> every valid data_out matches the bit-exact integer model of REQ-018.
REQ-027 Reset pulsed for 1 clock after 500 random samples, then constant 100 -> response is identical to REQ-023 relative to the new release.
